// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared types for the multi-channel clock divider.
//                div_mode_e selects 50% toggle or one-cycle tick output;
//                div_cfg_t bundles one channel's configuration.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    localparam int unsigned TERM_W = 32;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } div_mode_e;

    typedef struct packed {
        logic              en;
        div_mode_e         mode;
        logic [TERM_W-1:0] term;
    } div_cfg_t;

endpackage
`default_nettype wire

// File: rtl/clk_div_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi_if
//  Description : Configuration write bus for clk_div_multi.
//                Ports: cfg_we (write strobe), cfg_ch (target channel),
//                cfg_term (terminal count), cfg_mode (toggle/pulse),
//                cfg_en (channel enable). No ready: writes never stall.
//                master = config source, slave = divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface clk_div_multi_if
    import clk_div_pkg::div_mode_e;
#(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned TERM_W = 32
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [TERM_W-1:0] cfg_term;
    div_mode_e         cfg_mode;
    logic              cfg_en;

    modport master (output cfg_we, cfg_ch, cfg_term, cfg_mode, cfg_en);
    modport slave  (input  cfg_we, cfg_ch, cfg_term, cfg_mode, cfg_en);

endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel: counter, active and pending config,
//                registered toggle clock and tick outputs.
//                Ports: clk, rst (async, active high), we (write for this
//                channel), wr_term/wr_mode/wr_en (write data), sync (phase
//                realign), div_clk (toggle output), tick (pulse output),
//                pend (term/mode update waiting for the next wrap).
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::div_mode_e;
    import clk_div_pkg::MODE_TOGGLE;
    import clk_div_pkg::MODE_PULSE;
#(
    parameter int unsigned       TERM_W       = 32,
    parameter logic [TERM_W-1:0] DEFAULT_TERM = '0,
    parameter bit                RESET_EN     = 1'b1
)(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [TERM_W-1:0] wr_term,
    input  wire div_mode_e         wr_mode,
    input  wire logic              wr_en,
    input  wire logic              sync,
    output logic                   div_clk,
    output logic                   tick,
    output logic                   pend
);

    logic [TERM_W-1:0] r_cnt;
    logic [TERM_W-1:0] r_term;
    div_mode_e         r_mode;
    logic              r_en;
    logic              r_pend;
    logic [TERM_W-1:0] r_pend_term;
    div_mode_e         r_pend_mode;
    logic              r_clk;
    logic              r_tick;

    logic              w_wrap;
    logic [TERM_W-1:0] w_next_term;
    div_mode_e         w_next_mode;

    // Config taking effect at a wrap: a write landing on the wrap cycle wins
    // over an older pending value, which in turn wins over the active one.
    always_comb begin
        w_wrap      = r_en && (r_cnt == r_term);
        w_next_term = r_term;
        w_next_mode = r_mode;
        if (we) begin
            w_next_term = wr_term;
            w_next_mode = wr_mode;
        end else if (r_pend) begin
            w_next_term = r_pend_term;
            w_next_mode = r_pend_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_term      <= DEFAULT_TERM;
            r_mode      <= MODE_TOGGLE;
            r_en        <= RESET_EN;
            r_pend      <= 1'b0;
            r_pend_term <= DEFAULT_TERM;
            r_pend_mode <= MODE_TOGGLE;
            r_clk       <= 1'b0;
            r_tick      <= 1'b0;
        end else if (we && (!wr_en || !r_en)) begin
            // Disabling, or writing a disabled channel: config is applied at
            // once and the counter restarts from 0 when enabled.
            r_en    <= wr_en;
            r_term  <= wr_term;
            r_mode  <= wr_mode;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (!r_en) begin
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else if (sync) begin
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
            if (r_pend) begin
                r_term <= r_pend_term;
                r_mode <= r_pend_mode;
            end
            // A write alongside sync still lands in pending.
            r_pend <= we;
            if (we) begin
                r_pend_term <= wr_term;
                r_pend_mode <= wr_mode;
            end
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_term <= w_next_term;
            r_mode <= w_next_mode;
            r_pend <= 1'b0;
            if (w_next_mode != r_mode) begin
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else if (r_mode == MODE_TOGGLE) begin
                r_clk  <= ~r_clk;
                r_tick <= 1'b0;
            end else begin
                r_clk  <= 1'b0;
                r_tick <= 1'b1;
            end
        end else begin
            r_cnt  <= r_cnt + TERM_W'(1);
            r_tick <= 1'b0;
            if (we) begin
                r_pend      <= 1'b1;
                r_pend_term <= wr_term;
                r_pend_mode <= wr_mode;
            end
        end
    end

    // The unused output of each mode is held low by the update rules above.
    assign div_clk = r_clk;
    assign tick    = r_tick;
    assign pend    = r_pend;

    logic w_unused_pulse;
    assign w_unused_pulse = (MODE_PULSE == MODE_TOGGLE);

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_multi
//  Description : N-channel programmable clock divider / tick generator.
//                Each channel has a runtime terminal count T, a mode
//                (toggle: period 2(T+1); pulse: one-cycle tick every T+1)
//                and an enable. Term/mode writes to a running channel are
//                held pending until its next wrap.
//                Ports: clk, rst (async, active high), cfg (config write
//                bus, slave), clk_o / tick_o / pend_o (per channel).
//                Optional macro CLKDIV_SYNC_EN adds sync_i: a high cycle
//                restarts all enabled channels from count 0 and applies
//                any pending config.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::div_mode_e;
#(
    parameter int unsigned       N_CH         = 2,
    parameter int unsigned       TERM_W       = clk_div_pkg::TERM_W,
    parameter logic [TERM_W-1:0] DEFAULT_TERM = TERM_W'(49_999_999),
    parameter bit                RESET_EN     = 1'b1
)(
    input  wire logic       clk,
    input  wire logic       rst,
`ifdef CLKDIV_SYNC_EN
    input  wire logic       sync_i,
`endif
    clk_div_multi_if.slave  cfg,
    output logic [N_CH-1:0] clk_o,
    output logic [N_CH-1:0] tick_o,
    output logic [N_CH-1:0] pend_o
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic w_sync;
`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range channel indices match no channel and are dropped.
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_chan
            logic w_we;
            assign w_we = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));

            clk_div_chan #(
                .TERM_W       (TERM_W),
                .DEFAULT_TERM (DEFAULT_TERM),
                .RESET_EN     (RESET_EN)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .we      (w_we),
                .wr_term (cfg.cfg_term),
                .wr_mode (cfg.cfg_mode),
                .wr_en   (cfg.cfg_en),
                .sync    (w_sync),
                .div_clk (clk_o[i]),
                .tick    (tick_o[i]),
                .pend    (pend_o[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
